aha_ahb_code_region_mux: RTL and testbench
==========================================

// Module: aha_ahb_code_region_mux
// PURPOSE
//  Parametrised AHB-Lite code-region front end for the CM3 integration; generalises the single 64K code SRAM.
//  Decodes the code region into NUM_BANKS equal SRAM banks at base 0x0000_0000, one bank HSEL each.
//  Muxes bank responses back to the master; built-in default slave returns the spec two-cycle ERROR.
//  Adds per-bank write protection and a saturating decode-error counter.
// PARAMETERS
//  NUM_BANKS     4     number of SRAM banks, 1..16
//  BANK_ADDR_W   16    log2 bank size in bytes (16 = 64 KB per bank)
//  RO_BANK_MASK  4'b0  bit i set = bank i read-only; a write to it is an ERROR
//  ERR_CNT_W     16    width of ERR_COUNT
// PORTS
//  HCLK            in   1              clock; all logic on the rising edge
//  HRESET          in   1              synchronous reset, active-high
//  HSEL            in   1              region select from the bus matrix
//  HREADY          in   1              bus HREADY
//  HTRANS          in   2              transfer type
//  HSIZE           in   3              transfer size; unused internally, routed to banks at top level
//  HWRITE          in   1              write strobe (address phase)
//  HADDR           in   32             address
//  HREADYOUT       out  1              ready to master
//  HRESP           out  2              response to master; bit 1 is tied to 0
//  HRDATA          out  32             read data to master
//  BANK_HSEL       out  NUM_BANKS      one-hot bank select; bank gets HADDR/HTRANS/HWDATA directly
//  BANK_HREADYOUT  in   NUM_BANKS      bank ready
//  BANK_HRESP      in   2*NUM_BANKS    bank i at [2i+:2]
//  BANK_HRDATA     in   32*NUM_BANKS   bank i at [32i+:32]
//  ERR_CLR         in   1              clear ERR_COUNT
//  ERR_COUNT       out  ERR_CNT_W      saturating count of ERROR responses issued by the default slave
// BEHAVIOUR
//  - IDX_W=clog2(NUM_BANKS), min 1; idx=HADDR[BANK_ADDR_W+:IDX_W].
//  - hit: HADDR above bank+index field all zero and idx<NUM_BANKS. Non-power-of-2 NUM_BANKS leaves holes; holes miss.
//  - ap_valid = HSEL & HREADY & HTRANS[1].
//  - err = ap_valid & (~hit | (HWRITE & RO_BANK_MASK[idx])).
//  - BANK_HSEL[i] = HSEL & hit & (idx==i) & ~(HWRITE & RO_BANK_MASK[i]); combinational. Banks qualify with HREADY.
//  - FSM {IDLE, BANK, ERR1, ERR2}. Advances only when HREADY=1, except ERR1->ERR2, which is unconditional.
//  - On HREADY=1, from IDLE/BANK/ERR2:
//      err -> ERR1
//      ap_valid & hit -> BANK, latch dp_idx=idx
//      otherwise -> IDLE.
//  - Outputs by state:
//      IDLE: HREADYOUT=1, HRESP=00, HRDATA=0.
//      BANK: HREADYOUT/HRESP/HRDATA = bank[dp_idx] signals, passed through unmodified (bank ERROR included).
//      ERR1: HREADYOUT=0, HRESP=01.
//      ERR2: HREADYOUT=1, HRESP=01.
//      HRDATA=0 in IDLE and both ERR states.
//  - Latency: zero added cycles for bank hits. Every error transfer costs exactly 2 data-phase cycles.
//  - Back-to-back: a new address phase sampled in the ERR2 cycle is honoured, hit or error. IDLE/BUSY there -> IDLE.
//  - ERR_COUNT: +1 on each entry to ERR1; holds at all-ones.
//      ERR_CLR and increment in the same cycle -> 0 (clear wins).
//  - Reset: state=IDLE, dp_idx=0, ERR_COUNT=0.
//      So HREADYOUT=1, HRESP=00, HRDATA=0; BANK_HSEL follows its inputs.
//      Reset asserted mid-BANK or mid-ERR1 aborts to IDLE next edge; the bank response is ignored.
// STRUCTURE
//  - Shared package aha_code_region_pkg:
//      state encodings (IDLE=0, BANK=1, ERR1=2, ERR2=3)
//      HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants
//      clog2 function.
//  - One sub-module aha_code_region_decode: HADDR/HWRITE -> hit, idx, ro_violation, one-hot select. Purely combinational.
//  - FSM, data-phase registers, response mux and counter live in the top module.
// TESTING
//  1. NUM_BANKS=4, read 0x0002_0010 -> BANK_HSEL=0100.
//     Next cycle bank2 drives HRDATA=0xCAFE_F00D, HREADYOUT=1 -> master sees 0xCAFE_F00D, HRESP=00.
//  2. Read 0x0004_0000 (out of range) -> no BANK_HSEL.
//     Data phase: cycle1 HREADYOUT=0/HRESP=01, cycle2 HREADYOUT=1/HRESP=01. ERR_COUNT=1.
//  3. RO_BANK_MASK=4'b0001: write 0x0000_0004 -> BANK_HSEL=0000, two-cycle ERROR.
//     Read of the same address -> bank0 data, OKAY.
//  4. Back-to-back: error transfer, then NONSEQ read to bank1 presented during ERR2 -> bank1 data phase follows with no idle cycle.
//  5. Bank3 wait states: BANK_HREADYOUT low for 3 cycles -> HREADYOUT low 3 cycles. A new address held during them is not sampled.
//  6. HRESET pulsed in ERR1 -> next cycle HREADYOUT=1, HRESP=00.
//     Also: ERR_COUNT forced to 0xFFFF stays 0xFFFF on a further error; ERR_CLR with a simultaneous error -> 0.

Source files
------------

// File: rtl/aha_code_region_pkg.sv
// Purpose: shared types, AHB constants and helpers for the code-region front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aha_code_region_pkg;

    // Data-phase state of the region front end
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BANK = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Ceiling log2; returns 0 for n <= 1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aha_code_region_decode.sv
// Purpose: code-region address decode into NUM_BANKS equal banks with per-bank write protection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; HSEL/HREADY qualification is applied by the caller.
// Ports: haddr_i/hwrite_i in; hit_o, idx_o, ro_viol_o (write to read-only bank), sel_o (one-hot, unqualified) out.
module aha_code_region_decode #(
    parameter int          NUM_BANKS    = 4,
    parameter int          BANK_ADDR_W  = 16,
    parameter logic [15:0] RO_BANK_MASK = 16'h0000,
    parameter int          IDX_W        = 2
) (
    input  logic [31:0]          haddr_i,
    input  logic                 hwrite_i,
    output logic                 hit_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 ro_viol_o,
    output logic [NUM_BANKS-1:0] sel_o
);
    localparam int              TOP_LSB = BANK_ADDR_W + IDX_W;
    localparam logic [IDX_W:0]  NB      = (IDX_W + 1)'(NUM_BANKS);

    assign idx_o = haddr_i[BANK_ADDR_W +: IDX_W];

    // Index values past NUM_BANKS (non-power-of-2 counts) are holes and miss
    assign hit_o     = ((haddr_i >> TOP_LSB) == 32'd0) && ({1'b0, idx_o} < NB);
    assign ro_viol_o = hwrite_i & RO_BANK_MASK[idx_o];

    // A protected bank never sees the write; the default slave answers it instead
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_sel
        assign sel_o[i] = hit_o && (idx_o == IDX_W'(i)) && !(hwrite_i && RO_BANK_MASK[i]);
    end

endmodule

// File: rtl/aha_ahb_code_region_mux.sv
// Purpose: AHB-Lite code-region front end: bank decode, response mux, default ERROR slave, error counter.
// Latency: zero added cycles for bank hits; error transfers take exactly two data-phase cycles.
// Backpressure: bank HREADYOUT passes straight through; the FSM only advances on HREADY (except ERR1->ERR2).
// Ports: HCLK/HRESET (sync, active-high); AHB slave side HSEL..HADDR in, HREADYOUT/HRESP/HRDATA out;
//        BANK_HSEL one-hot out, BANK_HREADYOUT/HRESP/HRDATA packed per bank in; ERR_CLR in, ERR_COUNT out.
module aha_ahb_code_region_mux #(
    parameter int          NUM_BANKS    = 4,
    parameter int          BANK_ADDR_W  = 16,
    parameter logic [15:0] RO_BANK_MASK = 16'h0000,
    parameter int          ERR_CNT_W    = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic                    HREADY,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic                    HWRITE,
    input  logic [31:0]             HADDR,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    output logic [31:0]             HRDATA,
    output logic [NUM_BANKS-1:0]    BANK_HSEL,
    input  logic [NUM_BANKS-1:0]    BANK_HREADYOUT,
    input  logic [2*NUM_BANKS-1:0]  BANK_HRESP,
    input  logic [32*NUM_BANKS-1:0] BANK_HRDATA,
    input  logic                    ERR_CLR,
    output logic [ERR_CNT_W-1:0]    ERR_COUNT
);
    import aha_code_region_pkg::*;

    localparam int IDX_W_RAW = clog2(NUM_BANKS);
    localparam int IDX_W     = (IDX_W_RAW < 1) ? 1 : IDX_W_RAW;

    logic                 hit;
    logic [IDX_W-1:0]     idx;
    logic                 ro_viol;
    logic [NUM_BANKS-1:0] dec_sel;
    logic                 ap_valid;
    logic                 err;
    logic                 err_inc;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     dp_idx_q, dp_idx_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 bank_rdy;
    logic [1:0]           bank_resp;
    logic [31:0]          bank_rdata;

    aha_code_region_decode #(
        .NUM_BANKS    (NUM_BANKS),
        .BANK_ADDR_W  (BANK_ADDR_W),
        .RO_BANK_MASK (RO_BANK_MASK),
        .IDX_W        (IDX_W)
    ) u_decode (
        .haddr_i   (HADDR),
        .hwrite_i  (HWRITE),
        .hit_o     (hit),
        .idx_o     (idx),
        .ro_viol_o (ro_viol),
        .sel_o     (dec_sel)
    );

    // Banks qualify with HREADY themselves, so the select is not gated here
    assign BANK_HSEL = {NUM_BANKS{HSEL}} & dec_sel;
    assign ap_valid  = HSEL & HREADY & HTRANS[1];
    assign err       = ap_valid & (~hit | ro_viol);

    always_comb begin
        state_d  = state_q;
        dp_idx_d = dp_idx_q;
        err_inc  = 1'b0;
        if (state_q == ST_ERR1) begin
            // Our own HREADYOUT is low here, so HREADY cannot gate this step
            state_d = ST_ERR2;
        end else if (HREADY) begin
            if (err) begin
                state_d = ST_ERR1;
                err_inc = 1'b1;
            end else if (ap_valid && hit) begin
                state_d  = ST_BANK;
                dp_idx_d = idx;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ERR_CLR) begin
            err_cnt_d = '0;
        end else if (err_inc && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            dp_idx_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dp_idx_q  <= dp_idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        bank_rdy   = 1'b0;
        bank_resp  = HRESP_OKAY;
        bank_rdata = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (dp_idx_q == IDX_W'(i)) begin
                bank_rdy   = BANK_HREADYOUT[i];
                bank_resp  = BANK_HRESP[2*i +: 2];
                bank_rdata = BANK_HRDATA[32*i +: 32];
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        case (state_q)
            ST_BANK: begin
                HREADYOUT = bank_rdy;
                HRESP     = {1'b0, bank_resp[0]};
                HRDATA    = bank_rdata;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_ERROR;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    assign ERR_COUNT = err_cnt_q;

    // HSIZE is routed to the banks outside this block; bit 1 of HRESP is always zero
    logic unused_ok;
    assign unused_ok = ^{HSIZE, HTRANS[0], bank_resp[1]};

endmodule

// File: tb/tb_aha_ahb_code_region_mux.sv
module tb_aha_ahb_code_region_mux;
    localparam int NB = 4;
    localparam int K_NONE = 0;
    localparam int K_BANK = 1;
    localparam int K_ERR  = 2;

    logic            HCLK = 1'b0;
    logic            HRESET, HSEL, HREADY, HWRITE, ERR_CLR;
    logic [1:0]      HTRANS;
    logic [2:0]      HSIZE;
    logic [31:0]     HADDR;
    logic            HREADYOUT, HREADYOUT_S;
    logic [1:0]      HRESP, HRESP_S;
    logic [31:0]     HRDATA, HRDATA_S;
    logic [NB-1:0]   BANK_HSEL, BANK_HSEL_S;
    logic [NB-1:0]   BANK_HREADYOUT;
    logic [2*NB-1:0] BANK_HRESP;
    logic [32*NB-1:0] BANK_HRDATA;
    logic [15:0]     ERR_COUNT;
    logic [2:0]      ERR_COUNT_S;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    aha_ahb_code_region_mux #(.NUM_BANKS(NB), .BANK_ADDR_W(16), .RO_BANK_MASK(16'h0001), .ERR_CNT_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HADDR(HADDR), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .BANK_HSEL(BANK_HSEL), .BANK_HREADYOUT(BANK_HREADYOUT), .BANK_HRESP(BANK_HRESP),
        .BANK_HRDATA(BANK_HRDATA), .ERR_CLR(ERR_CLR), .ERR_COUNT(ERR_COUNT));

    // Narrow-counter copy on the same bus, used to reach saturation quickly
    aha_ahb_code_region_mux #(.NUM_BANKS(NB), .BANK_ADDR_W(16), .RO_BANK_MASK(16'h0001), .ERR_CNT_W(3)) dut_s (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HADDR(HADDR), .HREADYOUT(HREADYOUT_S), .HRESP(HRESP_S), .HRDATA(HRDATA_S),
        .BANK_HSEL(BANK_HSEL_S), .BANK_HREADYOUT(BANK_HREADYOUT), .BANK_HRESP(BANK_HRESP),
        .BANK_HRDATA(BANK_HRDATA), .ERR_CLR(ERR_CLR), .ERR_COUNT(ERR_COUNT_S));

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level reference: what data phase is in progress and how long it has left
    int          m_kind, m_wait, m_bank, m_cnt;
    bit          m_eph;
    logic [31:0] m_data;
    int          p_wait;
    logic [31:0] p_data;
    bit          cyc_done;
    logic        obs_rdy;
    logic [1:0]  obs_resp;
    logic [31:0] obs_rdata;
    logic [3:0]  obs_hsel;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  hsel;
        logic        err;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] hsel_of(input logic s, input logic [31:0] a, input logic w);
        int b;
        if (!s || a >= 32'h0004_0000) return 4'b0000;
        b = int'(a >> 16);
        if (w && b == 0) return 4'b0000;
        return 4'(1 << b);
    endfunction

    // One bus cycle: bank models drive, outputs are checked at negedge, model steps at posedge
    task automatic cycle();
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        logic [3:0]  e_hsel;
        int          c16, c3, b;
        for (int i = 0; i < NB; i++) begin
            BANK_HREADYOUT[i]       = 1'b1;
            BANK_HRESP[2*i +: 2]    = 2'b00;
            BANK_HRDATA[32*i +: 32] = $urandom;
        end
        e_rdy = 1'b1; e_resp = 2'b00; e_data = 32'h0;
        if (m_kind == K_BANK) begin
            BANK_HREADYOUT[m_bank]       = (m_wait == 0);
            BANK_HRDATA[32*m_bank +: 32] = m_data;
            e_rdy  = (m_wait == 0);
            e_data = m_data;
        end else if (m_kind == K_ERR) begin
            e_rdy  = m_eph;
            e_resp = 2'b01;
        end
        e_hsel = hsel_of(HSEL, HADDR, HWRITE);
        c16 = (m_cnt > 65535) ? 65535 : m_cnt;
        c3  = (m_cnt > 7) ? 7 : m_cnt;
        @(negedge HCLK);
        chk("hreadyout", HREADYOUT, e_rdy);
        chk("hresp", HRESP, e_resp);
        chk("hrdata", HRDATA, e_data);
        chk("bank_hsel", BANK_HSEL, e_hsel);
        chk("err_count", ERR_COUNT, c16);
        chk("hreadyout_s", HREADYOUT_S, e_rdy);
        chk("hresp_s", HRESP_S, e_resp);
        chk("hrdata_s", HRDATA_S, e_data);
        chk("err_count_s", ERR_COUNT_S, c3);
        obs_rdy = HREADYOUT; obs_resp = HRESP; obs_rdata = HRDATA; obs_hsel = BANK_HSEL;
        cyc_done = e_rdy;
        if (HRESET) begin
            m_kind = K_NONE; m_cnt = 0; m_wait = 0;
        end else begin
            if (e_rdy) begin
                if (HSEL && HTRANS[1]) begin
                    b = int'(HADDR >> 16);
                    if (HADDR >= 32'h0004_0000 || (HWRITE && b == 0)) begin
                        m_kind = K_ERR; m_eph = 1'b0; m_cnt++;
                    end else begin
                        m_kind = K_BANK; m_bank = b; m_wait = p_wait; m_data = p_data;
                    end
                end else begin
                    m_kind = K_NONE;
                end
            end else if (m_kind == K_BANK) begin
                m_wait--;
            end else if (m_kind == K_ERR) begin
                m_eph = 1'b1;
            end
            if (ERR_CLR) m_cnt = 0;
        end
        @(posedge HCLK);
        #1;
    endtask

    // Present an address phase and hold it until the bus accepts it
    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] t, input logic s,
                         input int wt, input logic [31:0] d, output int n, output logic [3:0] h0);
        HADDR = a; HWRITE = w; HTRANS = t; HSEL = s; p_wait = wt; p_data = d;
        n = 0; h0 = 4'b0;
        do begin
            cycle();
            if (n == 0) h0 = obs_hsel;
            n++;
        end while (!cyc_done && n < 20);
        if (!cyc_done) chk("issue_timeout", 32'(cyc_done), 32'd1);
    endtask

    task automatic idle(output int n);
        logic [3:0] h;
        issue(32'h0, 1'b0, 2'b00, 1'b0, 0, 32'h0, n, h);
    endtask

    task automatic do_reset();
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00;
        cycle();
        cycle();
        HRESET = 1'b0;
    endtask

    initial begin
        int n, terr;
        logic [3:0] h;
        logic [1:0] t;
        int r;
        logic [31:0] a;

        vt[0] = '{32'h0000_0004, 1'b0, 4'b0001, 1'b0};
        vt[1] = '{32'h0000_0004, 1'b1, 4'b0000, 1'b1};
        vt[2] = '{32'h0001_FFFC, 1'b1, 4'b0010, 1'b0};
        vt[3] = '{32'h0002_0010, 1'b0, 4'b0100, 1'b0};
        vt[4] = '{32'h0003_0000, 1'b1, 4'b1000, 1'b0};
        vt[5] = '{32'h0004_0000, 1'b0, 4'b0000, 1'b1};
        vt[6] = '{32'h8000_0000, 1'b0, 4'b0000, 1'b1};
        vt[7] = '{32'h0003_FFFF, 1'b0, 4'b1000, 1'b0};
        vt[8] = '{32'h0001_0000, 1'b0, 4'b0010, 1'b0};

        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
        HSIZE = 3'b010; ERR_CLR = 1'b0;
        BANK_HREADYOUT = '1; BANK_HRESP = '0; BANK_HRDATA = '0;
        m_kind = K_NONE; m_cnt = 0; m_wait = 0; m_bank = 0; m_eph = 1'b0; m_data = 32'h0;
        p_wait = 0; p_data = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Reset state
        idle(n);
        chk("reset_hreadyout", obs_rdy, 1'b1);
        chk("reset_hresp", obs_resp, 2'b00);
        chk("reset_hrdata", obs_rdata, 32'h0);
        chk("reset_errcnt", ERR_COUNT, 16'd0);

        // Decode table
        terr = 0;
        foreach (vt[i]) begin
            issue(vt[i].addr, vt[i].wr, 2'b10, 1'b1, 0, $urandom, n, h);
            chk("tbl_hsel", h, vt[i].hsel);
            terr += int'(vt[i].err);
        end
        idle(n);
        chk("tbl_errcnt", ERR_COUNT, terr);

        // Bank2 read
        do_reset();
        issue(32'h0002_0010, 1'b0, 2'b10, 1'b1, 0, 32'hCAFE_F00D, n, h);
        chk("t1_hsel", h, 4'b0100);
        idle(n);
        chk("t1_rdata", obs_rdata, 32'hCAFE_F00D);
        chk("t1_resp", obs_resp, 2'b00);

        // Out-of-range read: two error cycles
        issue(32'h0004_0000, 1'b0, 2'b10, 1'b1, 0, 32'h0, n, h);
        chk("t2_hsel", h, 4'b0000);
        idle(n);
        chk("t2_err_cycles", n, 2);
        chk("t2_errcnt", ERR_COUNT, 16'd1);

        // Error then bank1 read presented in ERR2: no idle gap
        issue(32'h0004_0000, 1'b0, 2'b10, 1'b1, 0, 32'h0, n, h);
        issue(32'h0001_0040, 1'b0, 2'b10, 1'b1, 0, 32'h1111_2222, n, h);
        chk("t4_accept_cycles", n, 2);
        idle(n);
        chk("t4_next_cycles", n, 1);
        chk("t4_rdata", obs_rdata, 32'h1111_2222);

        // Bank3 wait states with the next address held
        issue(32'h0003_0100, 1'b0, 2'b10, 1'b1, 3, 32'h3333_0003, n, h);
        issue(32'h0002_0000, 1'b0, 2'b10, 1'b1, 0, 32'h2222_0002, n, h);
        chk("t5_wait_cycles", n, 4);
        idle(n);
        chk("t5_rdata", obs_rdata, 32'h2222_0002);

        // Reset pulsed in ERR1
        issue(32'h0004_0000, 1'b0, 2'b10, 1'b1, 0, 32'h0, n, h);
        HTRANS = 2'b00; HSEL = 1'b0; HRESET = 1'b1;
        cycle();
        HRESET = 1'b0;
        cycle();
        chk("t6_err1_rst_rdy", obs_rdy, 1'b1);
        chk("t6_err1_rst_resp", obs_resp, 2'b00);
        chk("t6_err1_rst_cnt", ERR_COUNT, 16'd0);

        // Reset pulsed mid-BANK wait
        issue(32'h0003_0000, 1'b0, 2'b10, 1'b1, 3, 32'h5555_AAAA, n, h);
        HTRANS = 2'b00; HSEL = 1'b0; HRESET = 1'b1;
        cycle();
        HRESET = 1'b0;
        cycle();
        chk("t6_bank_rst_rdy", obs_rdy, 1'b1);
        chk("t6_bank_rst_data", obs_rdata, 32'h0);

        // Saturation of the narrow counter, then clear racing an increment
        for (int i = 0; i < 9; i++) issue(32'h0005_0000, 1'b0, 2'b10, 1'b1, 0, 32'h0, n, h);
        idle(n);
        chk("sat_count_s", ERR_COUNT_S, 3'd7);
        chk("sat_count", ERR_COUNT, 16'd9);
        ERR_CLR = 1'b1;
        issue(32'h0004_0000, 1'b1, 2'b10, 1'b1, 0, 32'h0, n, h);
        ERR_CLR = 1'b0;
        idle(n);
        chk("clr_wins", ERR_COUNT, 16'd0);
        chk("clr_wins_s", ERR_COUNT_S, 3'd0);

        // Randomized traffic against the reference
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = $urandom_range(0, 32'h0003_FFFF) & 32'hFFFF_FFFC;
            else if (r == 7) a = 32'h0004_0000 + $urandom_range(0, 32'hFFFF);
            else if (r == 8) a = $urandom;
            else             a = $urandom_range(0, 255);
            r = $urandom_range(0, 9);
            t = (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b01;
            ERR_CLR = ($urandom_range(0, 19) == 0);
            issue(a, 1'($urandom_range(0, 1)), t, ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 2), $urandom, n, h);
        end
        ERR_CLR = 1'b0;
        idle(n);
        idle(n);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
